// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one read per cycle to a 1-cycle
// synchronous memory, and buffers returned words in a 2-entry tagged queue.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_raddr,
    output logic        imem_ren,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t [QDEPTH-1:0] ent_q;
    logic [31:0]         fetch_pc_q, fetch_pc_d;
    logic                inflight_q;
    logic [31:0]         inflight_pc_q;
    logic [1:0]          occ_q, occ_d;
    logic                wptr_q, wptr_d;
    logic                rptr_q, rptr_d;
    logic                pop, push, issue;

    assign out_valid = (occ_q != 2'd0) & ~redirect_valid;
    assign out_inst  = ent_q[rptr_q].inst;
    assign out_pc    = ent_q[rptr_q].pc;
    assign pop       = out_valid & out_ready;
    // Data arriving during a redirect belongs to the abandoned path.
    assign push      = inflight_q & ~redirect_valid;

    // Reservation counts the in-flight word so the queue can never overflow;
    // gating with rst_n keeps the port quiet while reset is asserted.
    assign issue = rst_n & (redirect_valid |
                   (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop})));
    assign imem_ren = issue;

    always_comb begin
        imem_raddr = fetch_pc_q;
        if (!rst_n)
            imem_raddr = RESET_PC;
        else if (redirect_valid)
            imem_raddr = redirect_pc & 32'hFFFF_FFFC;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        occ_d      = occ_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        if (issue)
            fetch_pc_d = imem_raddr + 32'd4;
        if (redirect_valid) begin
            occ_d  = 2'd0;
            wptr_d = 1'b0;
            rptr_d = 1'b0;
        end else begin
            occ_d = occ_q + {1'b0, push} - {1'b0, pop};
            if (push)
                wptr_d = ~wptr_q;
            if (pop)
                rptr_d = ~rptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'd0;
            occ_q         <= 2'd0;
            wptr_q        <= 1'b0;
            rptr_q        <= 1'b0;
            ent_q         <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= issue;
            occ_q      <= occ_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            if (issue)
                inflight_pc_q <= imem_raddr;
            if (push)
                ent_q[wptr_q] <= '{inst: imem_rdata, pc: inflight_pc_q};
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a queue of issued PCs (with issue cycle)
// predicts requests, delivery order, latency and flush behaviour.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_raddr;
    logic        imem_ren;
    logic [31:0] imem_rdata = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    fetch_unit #(.RESET_PC(RST_PC), .QDEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_raddr(imem_raddr), .imem_ren(imem_ren), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        case (a)
            32'h0: memfn = 32'h0000_0013;
            32'h4: memfn = 32'h0010_0093;
            32'h8: memfn = 32'h0020_0113;
            default: memfn = (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
        endcase
    endfunction

    // Memory model: garbage returned on non-read cycles must be ignored.
    always @(posedge clk)
        imem_rdata <= imem_ren ? memfn(imem_raddr) : 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } item_t;

    item_t       q[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    int          n_del = 0;
    logic [31:0] next_req = RST_PC;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at a negedge: drive, check, advance model, wait for next negedge.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic        exp_valid, exp_ren, pop;
        logic [31:0] addr;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        exp_valid = !rv && q.size() > 0 && q[0].cyc <= cyc - 2;
        pop       = exp_valid && rdy;
        exp_ren   = rv || ((q.size() - (pop ? 1 : 0)) < 2);
        addr      = rv ? (rpc & 32'hFFFF_FFFC) : next_req;
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        chk("imem_ren", {31'd0, imem_ren}, {31'd0, exp_ren});
        if (exp_valid) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_inst", out_inst, memfn(q[0].pc));
        end
        if (exp_ren)
            chk("imem_raddr", imem_raddr, addr);
        if (rv)
            q.delete();
        if (pop) begin
            void'(q.pop_front());
            n_del++;
        end
        if (exp_ren) begin
            q.push_back('{pc: addr, cyc: cyc});
            next_req = addr + 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_imem_ren", {31'd0, imem_ren}, 32'd0);
        chk("rst_imem_raddr", imem_raddr, RST_PC);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        q.delete();
        next_req = RST_PC;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        chk("init_out_valid", {31'd0, out_valid}, 32'd0);
        chk("init_imem_ren", {31'd0, imem_ren}, 32'd0);
        chk("init_imem_raddr", imem_raddr, RST_PC);
        chk("init_out_pc", out_pc, 32'd0);
        chk("init_out_inst", out_inst, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running stream from reset.
        for (int i = 0; i < 12; i++) step(1'b0, 32'd0, 1'b1);

        // Backpressure from the very first cycle, then release.
        reset_pulse();
        for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 1'b1);

        // Redirects: aligned, misaligned, wrap, and held for several cycles.
        step(1'b1, 32'h0000_0100, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b1);
        step(1'b1, 32'h0000_0103, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b1);
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b1);
        step(1'b1, 32'h0000_0200, 1'b1);
        step(1'b1, 32'h0000_0300, 1'b0);
        step(1'b1, 32'h0000_0400, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b1);

        // Fill the queue, then reset asynchronously mid-stream.
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b0);
        reset_pulse();
        for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic        rv;
            logic [31:0] rpc;
            rv  = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       rpc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                1:       rpc = $urandom_range(0, 255);
                default: rpc = $urandom;
            endcase
            if (i % 200 == 199)
                reset_pulse();
            step(rv, rpc, $urandom_range(0, 3) != 0);
        end

        chk("delivered_progress", {31'd0, n_del > 200}, 32'd1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
